// File: rtl/uart_tx_fifo_reader.sv
// ============================================================================
// Module   : uart_tx_fifo_reader
// Purpose  : Pops bytes from the TX FIFO and sends them as 8N1 UART frames,
//            LSB first, on a 16x oversample tick. Define UART_TX_IRDA_EN for
//            IrDA SIR (3/16 pulse) line encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo_reader #(
  parameter int DIV16     = 27,
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy
);

  localparam logic [2:0]  c_ST_IDLE    = 3'd0;
  localparam logic [2:0]  c_ST_FETCH   = 3'd1;
  localparam logic [2:0]  c_ST_LATCH   = 3'd2;
  localparam logic [2:0]  c_ST_START   = 3'd3;
  localparam logic [2:0]  c_ST_DATA    = 3'd4;
  localparam logic [2:0]  c_ST_STOP    = 3'd5;
  localparam logic [15:0] c_PRESC_LAST = 16'(DIV16 - 1);
  localparam logic [2:0]  c_STOP_LAST  = 3'(STOP_BITS - 1);
`ifdef UART_TX_IRDA_EN
  localparam logic        c_IDLE_LEVEL = 1'b0;
`else
  localparam logic        c_IDLE_LEVEL = 1'b1;
`endif

  logic [2:0]  r_state;
  logic [15:0] r_presc;
  logic [3:0]  r_sub;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_tx;

  logic [2:0]  w_state_nx;
  logic [15:0] w_presc_nx;
  logic [3:0]  w_sub_nx;
  logic [2:0]  w_bit_nx;
  logic [7:0]  w_shift_nx;
  logic        w_level_nx;
  logic        w_tx_nx;
  logic        w_in_bit;
  logic        w_tick;
  logic        w_bit_end;
  logic        w_last_stop;
  logic        w_rd_req;

  assign w_in_bit    = (r_state == c_ST_START) | (r_state == c_ST_DATA) |
                       (r_state == c_ST_STOP);
  assign w_tick      = (r_presc == c_PRESC_LAST);
  assign w_bit_end   = w_in_bit & w_tick & (r_sub == 4'd15);
  assign w_last_stop = (r_state == c_ST_STOP) & w_bit_end & (r_bit_cnt == c_STOP_LAST);
  assign w_rd_req    = ~fifo_empty & ((r_state == c_ST_IDLE) | w_last_stop);

  // Read strobe is issued in the deciding cycle so back-to-back frames keep a
  // two-clock gap; it is gated by reset so an idle FIFO is never popped in reset.
  assign fifo_rd = reset & w_rd_req;
  assign busy    = (r_state != c_ST_IDLE) | fifo_rd;
  assign tx      = r_tx;

  always_comb begin
    w_state_nx = r_state;
    w_presc_nx = r_presc;
    w_sub_nx   = r_sub;
    w_bit_nx   = r_bit_cnt;
    w_shift_nx = r_shift;
    if (w_in_bit) begin
      if (w_tick) begin
        w_presc_nx = '0;
        w_sub_nx   = r_sub + 4'd1;
      end else begin
        w_presc_nx = r_presc + 16'd1;
      end
    end
    case (r_state)
      c_ST_IDLE:  if (w_rd_req) w_state_nx = c_ST_FETCH;
      c_ST_FETCH: w_state_nx = c_ST_LATCH;
      c_ST_LATCH: begin
        w_shift_nx = fifo_data;
        w_presc_nx = '0;
        w_sub_nx   = '0;
        w_bit_nx   = '0;
        w_state_nx = c_ST_START;
      end
      c_ST_START: if (w_bit_end) w_state_nx = c_ST_DATA;
      c_ST_DATA: begin
        if (w_bit_end) begin
          w_shift_nx = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_bit_nx   = '0;
            w_state_nx = c_ST_STOP;
          end else begin
            w_bit_nx = r_bit_cnt + 3'd1;
          end
        end
      end
      c_ST_STOP: begin
        if (w_bit_end) begin
          if (r_bit_cnt == c_STOP_LAST) begin
            w_bit_nx   = '0;
            w_state_nx = w_rd_req ? c_ST_FETCH : c_ST_IDLE;
          end else begin
            w_bit_nx = r_bit_cnt + 3'd1;
          end
        end
      end
      default: w_state_nx = c_ST_IDLE;
    endcase
  end

  // Line level of the upcoming cycle, derived from next-state values so tx
  // can be a plain register that changes exactly on bit boundaries.
  always_comb begin
    w_level_nx = 1'b1;
    case (w_state_nx)
      c_ST_START: w_level_nx = 1'b0;
      c_ST_DATA:  w_level_nx = w_shift_nx[0];
      default:    w_level_nx = 1'b1;
    endcase
  end

`ifdef UART_TX_IRDA_EN
  logic w_in_bit_nx;
  assign w_in_bit_nx = (w_state_nx == c_ST_START) | (w_state_nx == c_ST_DATA) |
                       (w_state_nx == c_ST_STOP);
  // SIR: a zero bit is a pulse in sub-bit slots 0..2, everything else is dark
  assign w_tx_nx = w_in_bit_nx & ~w_level_nx & (w_sub_nx < 4'd3);
`else
  assign w_tx_nx = w_level_nx;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= c_ST_IDLE;
      r_presc   <= '0;
      r_sub     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= c_IDLE_LEVEL;
    end else begin
      r_state   <= w_state_nx;
      r_presc   <= w_presc_nx;
      r_sub     <= w_sub_nx;
      r_bit_cnt <= w_bit_nx;
      r_shift   <= w_shift_nx;
      r_tx      <= w_tx_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_reader.sv
// ============================================================================
// Module   : tb_uart_tx_fifo_reader
// Purpose  : Self-checking bench for uart_tx_fifo_reader (STOP_BITS 1 and 2),
//            frame-offset reference model plus literal waveform pins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo_reader;

  localparam int DIV16  = 2;
  localparam int BITLEN = 16 * DIV16;
  localparam int TRLEN  = 8192;
`ifdef UART_TX_IRDA_EN
  localparam logic IDLE_LVL = 1'b0;
`else
  localparam logic IDLE_LVL = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rd_a;
  logic [1:0] tx_a;
  logic [1:0] busy_a;
  logic [1:0] empty_a;
  logic [7:0] fdata [2] = '{8'h00, 8'h00};
  logic [7:0] mem [2][16];
  int         wr_ptr [2] = '{0, 0};
  int         rd_ptr [2] = '{0, 0};

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      uart_tx_fifo_reader #(.DIV16(DIV16), .STOP_BITS(g + 1)) u_dut (
        .clock     (clk),
        .reset     (reset),
        .fifo_data (fdata[g]),
        .fifo_empty(empty_a[g]),
        .fifo_rd   (rd_a[g]),
        .tx        (tx_a[g]),
        .busy      (busy_a[g])
      );
      assign empty_a[g] = (wr_ptr[g] == rd_ptr[g]);
    end
  endgenerate

  // FIFO read port: data appears the cycle after the read strobe
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_a[i]) begin
        fdata[i]  <= mem[i][rd_ptr[i] % 16];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  // Reference model: a frame is described by its cycle offset k from the read
  // strobe (k=1,2 gap, k>=3 bits of BITLEN clocks), ending at last_k().
  bit         m_active [2] = '{1'b0, 1'b0};
  int         m_k      [2] = '{0, 0};
  logic [7:0] m_byte   [2] = '{8'h00, 8'h00};
  int         m_rdp    [2] = '{0, 0};
  logic       exp_rd_s [2];

  logic tr_tx   [2][TRLEN];
  logic tr_busy [2][TRLEN];
  logic tr_rd   [2][TRLEN];
  int   rd_log  [2][16];
  int   rd_n    [2] = '{0, 0};
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic int last_k(input int inst);
    return 2 + BITLEN * (9 + inst + 1);
  endfunction

  function automatic logic model_tx(input int k, input logic [7:0] b, input int inst);
    int   bitn;
    int   pos;
    logic level;
    if (k < 3 || k > last_k(inst)) return IDLE_LVL;
    bitn = (k - 3) / BITLEN;
    pos  = (k - 3) % BITLEN;
    if (bitn == 0)      level = 1'b0;
    else if (bitn <= 8) level = b[bitn - 1];
    else                level = 1'b1;
`ifdef UART_TX_IRDA_EN
    return (level == 1'b0) && (pos < 3 * DIV16);
`else
    return level;
`endif
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @cyc %0d: got %0h, expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic push(input int inst, input logic [7:0] b);
    mem[inst][wr_ptr[inst] % 16] = b;
    wr_ptr[inst] = wr_ptr[inst] + 1;
  endtask

  task automatic tick();
    logic e_rd;
    logic e_busy;
    logic e_tx;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        e_rd   = 1'b0;
        e_busy = 1'b0;
        e_tx   = IDLE_LVL;
      end else begin
        e_rd   = (!m_active[i] || m_k[i] == last_k(i)) && (wr_ptr[i] != m_rdp[i]);
        e_busy = m_active[i] || e_rd;
        e_tx   = m_active[i] ? model_tx(m_k[i], m_byte[i], i) : IDLE_LVL;
      end
      exp_rd_s[i] = e_rd;
      check("fifo_rd", i, 32'(rd_a[i]), 32'(e_rd));
      check("busy", i, 32'(busy_a[i]), 32'(e_busy));
      check("tx", i, 32'(tx_a[i]), 32'(e_tx));
      if (cyc < TRLEN) begin
        tr_tx[i][cyc]   = tx_a[i];
        tr_busy[i][cyc] = busy_a[i];
        tr_rd[i][cyc]   = rd_a[i];
      end
      if (e_rd && rd_n[i] < 16) begin
        rd_log[i][rd_n[i]] = cyc;
        rd_n[i] = rd_n[i] + 1;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_active[i] = 1'b0;
      end else if (exp_rd_s[i]) begin
        m_active[i] = 1'b1;
        m_k[i]      = 1;
        m_byte[i]   = mem[i][m_rdp[i] % 16];
        m_rdp[i]    = m_rdp[i] + 1;
      end else if (m_active[i]) begin
        if (m_k[i] == last_k(i)) m_active[i] = 1'b0;
        else m_k[i] = m_k[i] + 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((m_active[0] || m_active[1] || wr_ptr[0] != m_rdp[0] ||
                wr_ptr[1] != m_rdp[1]) && n < budget);
    if (n >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout waiting for idle after %0d cycles", budget);
    end
    repeat (4) tick();
  endtask

  function automatic logic tv(input int inst, input int idx);
    return (idx >= 0 && idx < TRLEN) ? tr_tx[inst][idx] : 1'bx;
  endfunction

  function automatic logic bv(input int inst, input int idx);
    return (idx >= 0 && idx < TRLEN) ? tr_busy[inst][idx] : 1'bx;
  endfunction

  function automatic logic rv(input int inst, input int idx);
    return (idx >= 0 && idx < TRLEN) ? tr_rd[inst][idx] : 1'bx;
  endfunction

  initial begin
    int r;
    int r1;
    int rc;
    int n;

    // Reset check: hold 100 ns, release with FIFO empty, watch 1000 clocks
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    repeat (1000) tick();
    check("idle_tx", 0, 32'(tv(0, cyc - 1)), 32'(IDLE_LVL));
    check("idle_busy", 0, 32'(bv(0, cyc - 1)), 32'd0);
    check("idle_rd", 0, 32'(rv(0, cyc - 1)), 32'd0);

    // Single byte 8'h02
    push(0, 8'h02);
    run_idle(1000);
    r = rd_log[0][0];
    check("sb_rd_pulse", 0, 32'(rv(0, r)), 32'd1);
    check("sb_rd_once", 0, 32'(rv(0, r + 1)), 32'd0);
    check("sb_busy_end", 0, 32'(bv(0, r + 322)), 32'd1);
    check("sb_busy_fall", 0, 32'(bv(0, r + 323)), 32'd0);
`ifdef UART_TX_IRDA_EN
    check("sb_start_pulse", 0, 32'(tv(0, r + 3)), 32'd1);
    check("sb_pulse_last", 0, 32'(tv(0, r + 8)), 32'd1);
    check("sb_pulse_end", 0, 32'(tv(0, r + 9)), 32'd0);
    check("sb_bit0_pulse", 0, 32'(tv(0, r + 35)), 32'd1);
    check("sb_bit1_dark", 0, 32'(tv(0, r + 67)), 32'd0);
    check("sb_bit2_pulse", 0, 32'(tv(0, r + 99)), 32'd1);
    check("sb_stop_dark", 0, 32'(tv(0, r + 291)), 32'd0);
`else
    check("sb_gap", 0, 32'(tv(0, r + 2)), 32'd1);
    check("sb_start", 0, 32'(tv(0, r + 3)), 32'd0);
    check("sb_start_end", 0, 32'(tv(0, r + 34)), 32'd0);
    check("sb_bit0", 0, 32'(tv(0, r + 35)), 32'd0);
    check("sb_bit0_end", 0, 32'(tv(0, r + 66)), 32'd0);
    check("sb_bit1", 0, 32'(tv(0, r + 67)), 32'd1);
    check("sb_bit1_end", 0, 32'(tv(0, r + 98)), 32'd1);
    check("sb_bit2", 0, 32'(tv(0, r + 99)), 32'd0);
    check("sb_stop", 0, 32'(tv(0, r + 291)), 32'd1);
`endif

    // Back-to-back 8'h06, 8'h0E
    push(0, 8'h06);
    push(0, 8'h0E);
    run_idle(1500);
    r1 = rd_log[0][1];
    check("b2b_no_early_rd", 0, 32'(rv(0, r1 + 321)), 32'd0);
    check("b2b_second_rd", 0, 32'(rv(0, r1 + 322)), 32'd1);
    check("b2b_busy_fetch", 0, 32'(bv(0, r1 + 323)), 32'd1);
    check("b2b_busy_latch", 0, 32'(bv(0, r1 + 324)), 32'd1);
`ifdef UART_TX_IRDA_EN
    check("b2b_gap", 0, 32'(tv(0, r1 + 324)), 32'd0);
    check("b2b_start2", 0, 32'(tv(0, r1 + 325)), 32'd1);
    check("b2b_06_bit1", 0, 32'(tv(0, r1 + 67)), 32'd0);
    check("b2b_0e_bit0", 0, 32'(tv(0, r1 + 322 + 35)), 32'd1);
`else
    check("b2b_gap", 0, 32'(tv(0, r1 + 324)), 32'd1);
    check("b2b_start2", 0, 32'(tv(0, r1 + 325)), 32'd0);
    check("b2b_06_bit1", 0, 32'(tv(0, r1 + 67)), 32'd1);
    check("b2b_0e_bit3", 0, 32'(tv(0, r1 + 322 + 131)), 32'd1);
`endif

    // STOP_BITS=2 instance, byte 8'h1E
    push(1, 8'h1E);
    run_idle(1000);
    r = rd_log[1][0];
    check("sb2_busy_end", 1, 32'(bv(1, r + 354)), 32'd1);
    check("sb2_busy_fall", 1, 32'(bv(1, r + 355)), 32'd0);
`ifdef UART_TX_IRDA_EN
    check("sb2_bit7_pulse", 1, 32'(tv(1, r + 259)), 32'd1);
    check("sb2_stop_first", 1, 32'(tv(1, r + 291)), 32'd0);
    check("sb2_stop_last", 1, 32'(tv(1, r + 354)), 32'd0);
`else
    check("sb2_bit1", 1, 32'(tv(1, r + 67)), 32'd1);
    check("sb2_bit7", 1, 32'(tv(1, r + 290)), 32'd0);
    check("sb2_stop_first", 1, 32'(tv(1, r + 291)), 32'd1);
    check("sb2_stop_last", 1, 32'(tv(1, r + 354)), 32'd1);
`endif

    // Mid-frame reset during data bit 3 of 8'h0E; 8'hA5 follows
    push(0, 8'h0E);
    push(0, 8'hA5);
    n = 0;
    while (!(m_active[0] && m_k[0] == 3 + 4 * BITLEN + 10) && n < 1000) begin
      tick();
      n++;
    end
    check("mfr_reached_bit3", 0, 32'(n < 1000), 32'd1);
    reset = 1'b0;
    rc = cyc;
    repeat (5) tick();
    reset = 1'b1;
    run_idle(1000);
    r = rd_log[0][4];
    check("mfr_busy_before", 0, 32'(bv(0, rc - 1)), 32'd1);
    check("mfr_tx_async", 0, 32'(tv(0, rc)), 32'(IDLE_LVL));
    check("mfr_busy_async", 0, 32'(bv(0, rc)), 32'd0);
    check("mfr_next_rd", 0, 32'(rv(0, r)), 32'd1);
`ifdef UART_TX_IRDA_EN
    check("mfr_a5_bit0", 0, 32'(tv(0, r + 35)), 32'd0);
    check("mfr_a5_bit1", 0, 32'(tv(0, r + 67)), 32'd1);
`else
    check("mfr_a5_bit0", 0, 32'(tv(0, r + 35)), 32'd1);
    check("mfr_a5_bit1", 0, 32'(tv(0, r + 67)), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
- Transmit side of the UART/IrDA link.
- Pops bytes from the transmit fifo_control instance (reader end of the FIFO write/read interface) and serialises each byte as an 8N1 UART frame, LSB first.
- Timing uses a 16x oversample tick, so the optional IrDA encoder can shape 3/16-bit pulses.
- Output drives the UART line or the IrDA transceiver.

Parameters:
- DIV16, 27: clock cycles per 1/16 bit period (50 MHz / (16*115200)); legal range 1..65535.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fifo_data  in  8  FIFO read data; valid the cycle after fifo_rd is asserted.
- fifo_empty  in  1  high when the FIFO holds no bytes.
- fifo_rd  out  1  one-cycle read strobe to the FIFO.
- tx  out  1  serial line output.
- busy  out  1  high from the fifo_rd pulse until the end of the last stop bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - fifo_rd=0, busy=0, tx=idle level (1; 0 with IRDA_EN).
  - State IDLE; prescaler, sub-bit counter, bit counter and shift register all cleared.
- Reset asserted mid-frame aborts the frame immediately. tx returns to idle; the byte is lost and is not re-read.
- State machine: IDLE -> FETCH -> LATCH -> START -> DATA -> STOP -> (FETCH or IDLE).
- IDLE:
  - tx idle.
  - If fifo_empty=0: fifo_rd=1 for exactly one cycle, busy=1, go to FETCH.
- FETCH: one wait cycle for FIFO read latency; fifo_rd=0.
- LATCH:
  - shift register <= fifo_data.
  - Prescaler and sub-bit counter <= 0.
  - Go to START.
- Tick generation:
  - Prescaler counts 0..DIV16-1; tick is asserted when prescaler==DIV16-1.
  - Sub-bit counter 0..15 advances on each tick.
  - A bit ends on the tick where sub-bit==15, so each bit lasts exactly 16*DIV16 clocks.
- START: line level for 0 for one bit period.
- DATA:
  - 8 bits, shift register bit 0 first; shift right at each bit end.
  - Bit counter 0..7; exit after bit 7.
- STOP:
  - STOP_BITS bit periods of line level 1.
  - At the end: if fifo_empty=0, assert fifo_rd in that same cycle and go to FETCH (busy stays 1). Otherwise go to IDLE and busy=0.
- Back-to-back frames: gap between the last stop bit and the next start bit is exactly 2 clocks (FETCH, LATCH).
- Latency from fifo_empty falling in IDLE to the start bit on tx: 3 clocks.
- fifo_empty is sampled only in IDLE and at the stop-bit end. Changes at any other time are ignored.
- fifo_rd is never asserted while fifo_empty=1.
- tx is a registered output; it must be glitch-free.

Optional Feature:
- Macro: UART_TX_IRDA_EN.
- Defined:
  - tx carries IrDA SIR encoding; idle level 0.
  - For each 0-valued bit (start bit and data zeros), tx=1 during sub-bit slots 0..2 (3/16 of the bit) and 0 for the rest of the bit.
  - 1-valued bits and stop bits are 0 throughout.
- Undefined:
  - Plain NRZ UART; tx = bit level for the whole bit; idle level 1.
  - No IrDA logic is synthesised.
- Frame timing, the FIFO handshake and busy are identical in both builds.

Test Plan:
- Reset check: DIV16=2, hold reset=0 for 100 ns, then release with fifo_empty=1.
  -> fifo_rd=0, busy=0, tx=1, and nothing changes for 1000 clocks.
- Single byte: FIFO presents 8'h02, fifo_empty falls.
  -> fifo_rd pulses for 1 clock.
  -> tx gives start 0, then data bits 0,1,0,0,0,0,0,0 and stop 1, each bit exactly 32 clocks.
  -> busy falls after 320 clocks of frame.
- Back-to-back: FIFO holds 8'h06 and 8'h0E.
  -> A second fifo_rd fires at the end of the first stop bit.
  -> The next start bit begins exactly 2 clocks later; bit patterns are correct.
  -> busy stays 1 throughout.
- STOP_BITS=2, byte 8'h1E.
  -> Stop level 1 holds for 64 clocks.
  -> Total frame is 352 clocks.
- Mid-frame reset: assert reset=0 during data bit 3 of 8'h0E.
  -> tx=1 and busy=0 asynchronously.
  -> After release, the next FIFO byte is read and sent intact.
- UART_TX_IRDA_EN defined, byte 8'h02.
  -> tx pulses high for 6 clocks at the start of the start bit and of each 0 data bit.
  -> tx stays low through the data-1 bit, the stop bit and idle.
